// File: rtl/locked_reg_programmer_if.sv
// -----------------------------------------------------------------------------
// locked_reg_programmer_if
//   Command channel between the boot/config agent and locked_reg_programmer.
//   Valid/ready handshake: a command transfers on a posedge where both
//   cmd_valid and cmd_ready are high.
//
//   Signals:
//     cmd_valid  agent -> programmer  command present
//     cmd_ready  programmer -> agent  programmer can accept a command
//     cmd_addr   agent -> programmer  target register index (ADDR_W)
//     cmd_data   agent -> programmer  value to program (DATA_W)
//     cmd_lock   agent -> programmer  lock the bank once this command verifies
//
//   Modports:
//     master  the command source (boot/config agent)
//     slave   the command sink (locked_reg_programmer)
// -----------------------------------------------------------------------------
interface locked_reg_programmer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_lock;

  modport master (
    output cmd_valid,
    output cmd_addr,
    output cmd_data,
    output cmd_lock,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_addr,
    input  cmd_data,
    input  cmd_lock,
    output cmd_ready
  );
endinterface

// File: rtl/locked_reg_programmer.sv
// -----------------------------------------------------------------------------
// locked_reg_programmer
//   Initiator-side sequencer for a bank of write-once locked registers.
//   Each accepted command is written to the bank with a one-cycle strobe,
//   read back one cycle later, and, when requested, followed by a one-cycle
//   lock strobe. Errors and successful locking are sticky until reset.
//
//   Optional macro: LOCKED_REG_PROG_RETRY_EN
//     When defined, the first verify mismatch of a command re-issues the
//     write once; only a second mismatch fails. When undefined, the first
//     mismatch fails and no retry state exists.
//
//   Ports:
//     Clk         in   system clock, posedge
//     resetn      in   asynchronous active-low reset
//     cmd         if   command channel (locked_reg_programmer_if.slave)
//     reg_sel     out  register select to the bank
//     reg_wdata   out  write data to the bank
//     reg_write   out  single-cycle write strobe
//     reg_lock    out  single-cycle lock strobe
//     reg_rdata   in   readback of the selected register
//     reg_locked  in   bank lock status
//     done        out  sticky: bank locked successfully
//     err         out  sticky error flag
//     err_code    out  0 none, 1 verify mismatch, 2 bad address, 3 already locked
// -----------------------------------------------------------------------------
module locked_reg_programmer #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2
) (
  input  logic                      Clk,
  input  logic                      resetn,
  locked_reg_programmer_if.slave    cmd,
  output logic [ADDR_W-1:0]         reg_sel,
  output logic [DATA_W-1:0]         reg_wdata,
  output logic                      reg_write,
  output logic                      reg_lock,
  input  logic [DATA_W-1:0]         reg_rdata,
  input  logic                      reg_locked,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_VERIFY, S_LOCK, S_WAIT_LK, S_LOCKED, S_FAIL
  } state_t;

  localparam logic [1:0] ERR_VERIFY = 2'd1;
  localparam logic [1:0] ERR_ADDR   = 2'd2;
  localparam logic [1:0] ERR_LOCKED = 2'd3;

  state_t              state_reg;
  logic                cmd_ready_reg;
  logic [ADDR_W-1:0]   reg_sel_reg;
  logic [DATA_W-1:0]   reg_wdata_reg;   // doubles as the latched command data
  logic                reg_write_reg;
  logic                reg_lock_reg;
  logic                lock_req_reg;
  logic [1:0]          wait_cnt_reg;
  logic                done_reg;
  logic                err_reg;
  logic [1:0]          err_code_reg;
`ifdef LOCKED_REG_PROG_RETRY_EN
  logic                retry_used_reg;
`endif

  // Widen both sides so the range check stays meaningful for any NUM_REGS.
  logic addr_bad;
  assign addr_bad = (32'(cmd.cmd_addr) >= 32'(NUM_REGS));

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      cmd_ready_reg  <= 1'b0;
      reg_sel_reg    <= '0;
      reg_wdata_reg  <= '0;
      reg_write_reg  <= 1'b0;
      reg_lock_reg   <= 1'b0;
      lock_req_reg   <= 1'b0;
      wait_cnt_reg   <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      err_code_reg   <= '0;
`ifdef LOCKED_REG_PROG_RETRY_EN
      retry_used_reg <= 1'b0;
`endif
    end else begin
      // Strobes are one cycle wide unless a state re-arms them.
      reg_write_reg <= 1'b0;
      reg_lock_reg  <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (!cmd_ready_reg) begin
            // First cycle out of reset: advertise readiness.
            cmd_ready_reg <= 1'b1;
          end else if (cmd.cmd_valid) begin
            cmd_ready_reg <= 1'b0;
            lock_req_reg  <= cmd.cmd_lock;
`ifdef LOCKED_REG_PROG_RETRY_EN
            retry_used_reg <= 1'b0;
`endif
            if (addr_bad) begin
              state_reg    <= S_FAIL;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_ADDR;
            end else if (reg_locked) begin
              state_reg    <= S_FAIL;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_LOCKED;
            end else begin
              state_reg     <= S_WRITE;
              reg_sel_reg   <= cmd.cmd_addr;
              reg_wdata_reg <= cmd.cmd_data;
              reg_write_reg <= 1'b1;
            end
          end
        end

        S_WRITE: state_reg <= S_VERIFY;

        // reg_rdata now reflects the write committed at the end of S_WRITE.
        S_VERIFY: begin
          if (reg_rdata != reg_wdata_reg) begin
`ifdef LOCKED_REG_PROG_RETRY_EN
            if (!retry_used_reg) begin
              retry_used_reg <= 1'b1;
              state_reg      <= S_WRITE;
              reg_write_reg  <= 1'b1;
            end else begin
              state_reg    <= S_FAIL;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_VERIFY;
            end
`else
            state_reg    <= S_FAIL;
            err_reg      <= 1'b1;
            err_code_reg <= ERR_VERIFY;
`endif
          end else if (lock_req_reg) begin
            state_reg    <= S_LOCK;
            reg_lock_reg <= 1'b1;
            wait_cnt_reg <= '0;
          end else begin
            state_reg     <= S_IDLE;
            cmd_ready_reg <= 1'b1;
          end
        end

        S_LOCK: state_reg <= S_WAIT_LK;

        // Four cycles of grace for the bank to report the lock.
        S_WAIT_LK: begin
          if (reg_locked) begin
            state_reg <= S_LOCKED;
            done_reg  <= 1'b1;
          end else if (wait_cnt_reg == 2'd3) begin
            state_reg    <= S_FAIL;
            err_reg      <= 1'b1;
            err_code_reg <= ERR_LOCKED;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 2'd1;
          end
        end

        // S_LOCKED and S_FAIL are terminal: outputs hold, nothing is issued.
        default: state_reg <= state_reg;
      endcase
    end
  end

  assign cmd.cmd_ready = cmd_ready_reg;
  assign reg_sel       = reg_sel_reg;
  assign reg_wdata     = reg_wdata_reg;
  assign reg_write     = reg_write_reg;
  assign reg_lock      = reg_lock_reg;
  assign done          = done_reg;
  assign err           = err_reg;
  assign err_code      = err_code_reg;

endmodule

// File: tb/tb_locked_reg_programmer.sv
// -----------------------------------------------------------------------------
// tb_locked_reg_programmer
//   Directed bench for locked_reg_programmer. A small behavioural register
//   bank answers the main instance; a second instance with NUM_REGS=3 is used
//   for the out-of-range address case. Inputs change and outputs are sampled
//   on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_locked_reg_programmer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // ---------------- main instance (NUM_REGS = 4) ----------------
  locked_reg_programmer_if #(.DATA_W(16), .ADDR_W(2)) cmd_if ();
  logic [1:0]  reg_sel;
  logic [15:0] reg_wdata;
  logic        reg_write;
  logic        reg_lock;
  logic [15:0] reg_rdata;
  logic        reg_locked;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  locked_reg_programmer #(.NUM_REGS(4), .DATA_W(16), .ADDR_W(2)) u_dut (
    .Clk        (clk),
    .resetn     (resetn),
    .cmd        (cmd_if),
    .reg_sel    (reg_sel),
    .reg_wdata  (reg_wdata),
    .reg_write  (reg_write),
    .reg_lock   (reg_lock),
    .reg_rdata  (reg_rdata),
    .reg_locked (reg_locked),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  // ---------------- second instance (NUM_REGS = 3) ----------------
  locked_reg_programmer_if #(.DATA_W(16), .ADDR_W(2)) cmd3_if ();
  logic [1:0]  reg_sel3;
  logic [15:0] reg_wdata3;
  logic        reg_write3;
  logic        reg_lock3;
  logic [15:0] reg_rdata3;
  logic        reg_locked3;
  logic        done3;
  logic        err3;
  logic [1:0]  err_code3;

  assign reg_rdata3  = 16'h0000;
  assign reg_locked3 = 1'b0;

  locked_reg_programmer #(.NUM_REGS(3), .DATA_W(16), .ADDR_W(2)) u_dut3 (
    .Clk        (clk),
    .resetn     (resetn),
    .cmd        (cmd3_if),
    .reg_sel    (reg_sel3),
    .reg_wdata  (reg_wdata3),
    .reg_write  (reg_write3),
    .reg_lock   (reg_lock3),
    .reg_rdata  (reg_rdata3),
    .reg_locked (reg_locked3),
    .done       (done3),
    .err        (err3),
    .err_code   (err_code3)
  );

  // ---------------- behavioural bank model ----------------
  logic        bank_clr;
  logic        stuck_zero;     // readback always returns zero
  logic        force_locked;   // bank reports locked regardless
  logic [15:0] regs [4];
  logic        bank_locked;
  int          wr_cnt = 0;
  int          lk_cnt = 0;
  int          wr3_cnt = 0;

  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 4; i++) regs[i] <= 16'h0000;
      bank_locked <= 1'b0;
    end else begin
      if (reg_write && !bank_locked) regs[reg_sel] <= reg_wdata;
      if (reg_lock) bank_locked <= 1'b1;
    end
    if (reg_write)  wr_cnt  <= wr_cnt + 1;
    if (reg_lock)   lk_cnt  <= lk_cnt + 1;
    if (reg_write3) wr3_cnt <= wr3_cnt + 1;
  end

  assign reg_rdata  = stuck_zero ? 16'h0000 : regs[reg_sel];
  assign reg_locked = bank_locked | force_locked;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command and return on the falling edge one cycle after the
  // handshake (the cycle in which reg_write should be high).
  task automatic send(input logic [1:0] a, input logic [15:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_addr  = a;
    cmd_if.cmd_data  = d;
    cmd_if.cmd_lock  = l;
    while (cmd_if.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("handshake_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    $display("txn addr=%0d data=%h lock=%0d", a, d, l);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn       = 1'b0;
    bank_clr     = 1'b1;
    stuck_zero   = 1'b0;
    force_locked = 1'b0;
    repeat (2) @(negedge clk);
    resetn   = 1'b1;
    bank_clr = 1'b0;
    @(negedge clk);
  endtask

  int w0, l0;

  initial begin
    resetn            = 1'b0;
    bank_clr          = 1'b1;
    stuck_zero        = 1'b0;
    force_locked      = 1'b0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_addr   = '0;
    cmd_if.cmd_data   = '0;
    cmd_if.cmd_lock   = 1'b0;
    cmd3_if.cmd_valid = 1'b0;
    cmd3_if.cmd_addr  = '0;
    cmd3_if.cmd_data  = '0;
    cmd3_if.cmd_lock  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    resetn   = 1'b1;
    bank_clr = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // Bad address on the NUM_REGS=3 instance
    cmd3_if.cmd_valid = 1'b1;
    cmd3_if.cmd_addr  = 2'd3;
    cmd3_if.cmd_data  = 16'h7777;
    check("bad_addr_ready", 32'(cmd3_if.cmd_ready), 32'd1);
    @(negedge clk);
    cmd3_if.cmd_valid = 1'b0;
    $display("txn(n3) addr=3 data=7777 lock=0");
    @(negedge clk);
    check("bad_addr_err",   32'(err3), 32'd1);
    check("bad_addr_code",  32'(err_code3), 32'd2);
    check("bad_addr_write", 32'(wr3_cnt), 32'd0);

    // Plain write without lock
    w0 = wr_cnt;
    send(2'd1, 16'hA5A5, 1'b0);
    check("t1_write", 32'(reg_write), 32'd1);
    check("t1_sel",   32'(reg_sel), 32'd1);
    check("t1_wdata", 32'(reg_wdata), 32'hA5A5);
    check("t1_ready_c1", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk);
    check("t1_write_c2", 32'(reg_write), 32'd0);
    check("t1_ready_c2", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk);
    check("t1_ready_c3", 32'(cmd_if.cmd_ready), 32'd1);
    check("t1_err",  32'(err), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    check("t1_wcnt", 32'(wr_cnt - w0), 32'd1);

    // Two writes, the second with lock
    w0 = wr_cnt;
    l0 = lk_cnt;
    send(2'd0, 16'h1111, 1'b0);
    repeat (2) @(negedge clk);
    send(2'd3, 16'h3333, 1'b1);
    check("t2_sel", 32'(reg_sel), 32'd3);
    @(negedge clk);
    @(negedge clk);
    check("t2_lock_c3",  32'(reg_lock), 32'd1);
    check("t2_write_c3", 32'(reg_write), 32'd0);
    @(negedge clk);
    check("t2_lock_c4", 32'(reg_lock), 32'd0);
    check("t2_done_c4", 32'(done), 32'd0);
    @(negedge clk);
    check("t2_done_c5", 32'(done), 32'd1);
    check("t2_err",  32'(err), 32'd0);
    check("t2_wcnt", 32'(wr_cnt - w0), 32'd2);
    check("t2_lcnt", 32'(lk_cnt - l0), 32'd1);
    w0 = wr_cnt;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_addr  = 2'd2;
    repeat (6) @(negedge clk);
    check("t2_locked_ready", 32'(cmd_if.cmd_ready), 32'd0);
    check("t2_locked_wcnt",  32'(wr_cnt - w0), 32'd0);
    check("t2_locked_done",  32'(done), 32'd1);
    cmd_if.cmd_valid = 1'b0;

    // Verify mismatch
    do_reset();
    stuck_zero = 1'b1;
    w0 = wr_cnt;
    l0 = lk_cnt;
    send(2'd2, 16'h1234, 1'b1);
    repeat (6) @(negedge clk);
    check("t3_err",  32'(err), 32'd1);
    check("t3_code", 32'(err_code), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_lcnt", 32'(lk_cnt - l0), 32'd0);
`ifdef LOCKED_REG_PROG_RETRY_EN
    check("t3_wcnt", 32'(wr_cnt - w0), 32'd2);
`else
    check("t3_wcnt", 32'(wr_cnt - w0), 32'd1);
`endif

    // Bank already locked at handshake
    do_reset();
    force_locked = 1'b1;
    w0 = wr_cnt;
    send(2'd1, 16'h5555, 1'b0);
    @(negedge clk);
    check("t4_err",  32'(err), 32'd1);
    check("t4_code", 32'(err_code), 32'd3);
    check("t4_wcnt", 32'(wr_cnt - w0), 32'd0);

    // Reset asserted during VERIFY
    do_reset();
    send(2'd1, 16'hBEEF, 1'b0);
    @(negedge clk);               // VERIFY cycle
    resetn = 1'b0;
    #1;
    check("t5_rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
    check("t5_rst_sel",   32'(reg_sel), 32'd0);
    check("t5_rst_wdata", 32'(reg_wdata), 32'd0);
    check("t5_rst_flags", {28'd0, reg_write, reg_lock, done, err}, 32'd0);
    check("t5_rst_code",  32'(err_code), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("t5_ready", 32'(cmd_if.cmd_ready), 32'd1);
    send(2'd2, 16'hCAFE, 1'b1);
    check("t5_wdata", 32'(reg_wdata), 32'hCAFE);
    repeat (4) @(negedge clk);
    check("t5_done", 32'(done), 32'd1);
    check("t5_err",  32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
